core_161c: RTL and testbench
============================

// Module: core_161c
// PURPOSE
//  16K x 36-bit core memory module on the DEC KA10 memory bus, four processor ports (p0..p3).
//  Arbitrates port requests, runs one read / write / read-modify-write cycle at a time.
//  Sits beside the KA10 CPU in the pdp10 top; its mb_out is wired-OR with the CPU's bus drive.
// PARAMETERS
//  memsel_p0  4'b0  value of membus_sel_p0[18:21] that selects this module on port 0
//  memsel_p1  4'b0  same, port 1
//  memsel_p2  4'b0  same, port 2
//  memsel_p3  4'b0  same, port 3
// PORTS  (N = 0..3, one copy per port; bit 0 = MSB, PDP-10 numbering)
//  clk                   in   1   single system clock, all logic on posedge
//  reset                 in   1   asynchronous, active-high
//  power                 in   1   module powered; 0 = idle, all outputs 0
//  sw_single_step        in   1   halt after each completed cycle
//  sw_restart            in   1   leave single-step halt / abort hung cycle
//  membus_rq_cyc_pN      in   1   port requests a memory cycle
//  membus_rd_rq_pN       in   1   cycle includes a read
//  membus_wr_rq_pN       in   1   cycle includes a write
//  membus_sel_pN         in   4   [18:21] module select, compared with memsel_pN
//  membus_ma_pN          in   15  [21:35] address; word index = ma[22:35]
//  membus_fmc_select_pN  in   1   fast memory (AC) addressed; module must not respond
//  membus_wr_rs_pN       in   1   write-data strobe from processor
//  membus_mb_in_pN       in   36  [0:35] write data (wired-OR bus)
//  membus_addr_ack_pN    out  1   address accepted, 1-clock pulse
//  membus_rd_rs_pN       out  1   read data valid, 1-clock pulse
//  membus_mb_out_pN      out  36  [0:35] read data; 0 whenever not strobing
// BEHAVIOUR
//  - Reset (async) or power=0: state IDLE, all outputs 0, single-step halt cleared; array contents kept.
//  - Port N is requesting when rq_cyc & (rd_rq|wr_rq) & sel==memsel_pN & ~fmc_select & power.
//  - Arbitration in IDLE only: fixed priority p0 > p1 > p2 > p3; unselected ports ignored.
//  - States: IDLE, ACK, RD_WAIT, RD_STROBE, WR_WAIT, WR_CYCLE, DONE, HALT.
//  - IDLE -> ACK: latch port index, ma[22:35], rd/wr flags; next clk pulse addr_ack of that port.
//  - Read (rd_rq): RD_WAIT 4 clks after addr_ack, then RD_STROBE: rd_rs=1 and mb_out=word for
//    exactly one clk on the granted port only; other ports' mb_out stay 0.
//  - Read only: after strobe -> DONE (core restore, word unchanged).
//  - Write / read-modify-write: WR_WAIT until wr_rs of granted port; on that clk latch mb_in
//    (own mb_out is 0 then), WR_CYCLE 4 clks, array[addr] <= data, -> DONE.
//  - wr_rs before addr_ack or on a non-granted port ignored; wr_rs in RD_STROBE clk ignored.
//  - DONE -> IDLE after requester drops rq_cyc (no double service of same request);
//    if sw_single_step, DONE -> HALT; HALT -> IDLE on sw_restart.
//  - sw_restart in WR_WAIT aborts cycle (array unchanged) -> IDLE.
//  - power falling mid-cycle: cycle aborted, write not performed.
//  - Simultaneous requests: lower-numbered port wins; loser waits, served after DONE.
//  - Address wrap not possible: 14-bit index covers all 16384 words.
// STRUCTURE
//  - Shared package: word width 36, address width 14, state enum, latency constants RD_DLY=4, WR_DLY=4.
//  - One sub-module natural: core_161c_arb (4-way fixed-priority grant + per-port select decode).
//  - Storage: 16384x36 reg array, single read/write port, inferable as block RAM.
// TESTING
//  - p0 write 36'o201040001234 @ ma=0o20 (sel=0) then read -> rd_rs 5 clks after addr_ack, mb_out=value.
//  - RMW on p0: read old value, wr_rs with 36'o777777777777 -> later read returns all ones.
//  - sel=4'b0001 with memsel_p0=0, or fmc_select=1 -> no addr_ack, no rd_rs, mb_out stays 0.
//  - p0 and p2 request in same clk -> p0 acked first, p2 acked only after p0 DONE.
//  - power=0 during WR_CYCLE -> outputs 0, word unchanged on later read.
//  - sw_single_step=1: after one cycle no further ack until sw_restart pulse.

Source files
------------

// File: rtl/core_161c_pkg.sv
// Shared definitions for the core_161c memory module: word/address geometry,
// controller states and access latencies.
package core_161c_pkg;
    localparam int WORD_W = 36;
    localparam int ADDR_W = 14;
    localparam int MA_W   = 15;
    localparam int SEL_W  = 4;
    localparam int NPORT  = 4;
    localparam int PORT_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RD_DLY = 4;
    localparam int WR_DLY = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE, ACK, RD_WAIT, RD_STROBE, WR_WAIT, WR_CYCLE, DONE, HALT
    } state_t;

    // Counter value seen on the final clock of a delay of 'dly' clocks.
    function automatic logic [CNT_W-1:0] last_cnt(input int dly);
        return CNT_W'(dly - 1);
    endfunction
endpackage

// File: rtl/core_161c_arb.sv
// core_161c_arb: decides which ports are addressing this module and picks the
// lowest-numbered one. Purely combinational; the controller samples it in IDLE.
module core_161c_arb
    import core_161c_pkg::*;
#(
    parameter logic [SEL_W*NPORT-1:0] memsel_bus = '0
) (
    input  logic                     power,
    input  logic [NPORT-1:0]         rq_cyc,
    input  logic [NPORT-1:0]         rd_rq,
    input  logic [NPORT-1:0]         wr_rq,
    input  logic [NPORT-1:0]         fmc_select,
    input  logic [SEL_W*NPORT-1:0]   sel,
    output logic                     grant_vld,
    output logic [PORT_W-1:0]        grant_idx
);
    logic [NPORT-1:0] req;

    // A port requests when it asks for a real cycle, selects us, and is not an AC access
    always_comb begin
        req = '0;
        for (int n = 0; n < NPORT; n++) begin
            req[n] = rq_cyc[n] & (rd_rq[n] | wr_rq[n]) & ~fmc_select[n] & power
                     & (sel[n*SEL_W +: SEL_W] == memsel_bus[n*SEL_W +: SEL_W]);
        end
    end

    // Fixed priority: scanning downward lets the lowest requesting port win
    always_comb begin
        grant_vld = |req;
        grant_idx = '0;
        for (int n = NPORT - 1; n >= 0; n--) begin
            if (req[n]) grant_idx = PORT_W'(n);
        end
    end
endmodule

// File: rtl/core_161c.sv
// core_161c: 16K x 36 core memory on the KA10 memory bus with four ports.
// Runs one read, write or read-modify-write cycle at a time. Bus vectors are
// little-endian here: bit [0] corresponds to PDP-10 bit 35.
module core_161c
    import core_161c_pkg::*;
#(
    parameter logic [SEL_W-1:0] memsel_p0 = 4'b0,
    parameter logic [SEL_W-1:0] memsel_p1 = 4'b0,
    parameter logic [SEL_W-1:0] memsel_p2 = 4'b0,
    parameter logic [SEL_W-1:0] memsel_p3 = 4'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic              sw_single_step,
    input  logic              sw_restart,
    input  logic              membus_rq_cyc_p0,
    input  logic              membus_rd_rq_p0,
    input  logic              membus_wr_rq_p0,
    input  logic [SEL_W-1:0]  membus_sel_p0,
    input  logic [MA_W-1:0]   membus_ma_p0,
    input  logic              membus_fmc_select_p0,
    input  logic              membus_wr_rs_p0,
    input  logic [WORD_W-1:0] membus_mb_in_p0,
    output logic              membus_addr_ack_p0,
    output logic              membus_rd_rs_p0,
    output logic [WORD_W-1:0] membus_mb_out_p0,
    input  logic              membus_rq_cyc_p1,
    input  logic              membus_rd_rq_p1,
    input  logic              membus_wr_rq_p1,
    input  logic [SEL_W-1:0]  membus_sel_p1,
    input  logic [MA_W-1:0]   membus_ma_p1,
    input  logic              membus_fmc_select_p1,
    input  logic              membus_wr_rs_p1,
    input  logic [WORD_W-1:0] membus_mb_in_p1,
    output logic              membus_addr_ack_p1,
    output logic              membus_rd_rs_p1,
    output logic [WORD_W-1:0] membus_mb_out_p1,
    input  logic              membus_rq_cyc_p2,
    input  logic              membus_rd_rq_p2,
    input  logic              membus_wr_rq_p2,
    input  logic [SEL_W-1:0]  membus_sel_p2,
    input  logic [MA_W-1:0]   membus_ma_p2,
    input  logic              membus_fmc_select_p2,
    input  logic              membus_wr_rs_p2,
    input  logic [WORD_W-1:0] membus_mb_in_p2,
    output logic              membus_addr_ack_p2,
    output logic              membus_rd_rs_p2,
    output logic [WORD_W-1:0] membus_mb_out_p2,
    input  logic              membus_rq_cyc_p3,
    input  logic              membus_rd_rq_p3,
    input  logic              membus_wr_rq_p3,
    input  logic [SEL_W-1:0]  membus_sel_p3,
    input  logic [MA_W-1:0]   membus_ma_p3,
    input  logic              membus_fmc_select_p3,
    input  logic              membus_wr_rs_p3,
    input  logic [WORD_W-1:0] membus_mb_in_p3,
    output logic              membus_addr_ack_p3,
    output logic              membus_rd_rs_p3,
    output logic [WORD_W-1:0] membus_mb_out_p3
);
    logic [NPORT-1:0]       rq_cyc, rd_rq, wr_rq, fmc_sel, wr_rs;
    logic [SEL_W*NPORT-1:0] sel_bus;
    logic [ADDR_W-1:0]      ma_idx [NPORT];
    logic [WORD_W-1:0]      mb_in  [NPORT];
    logic                   unused_ma_msb;

    assign rq_cyc  = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
    assign rd_rq   = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
    assign wr_rq   = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
    assign fmc_sel = {membus_fmc_select_p3, membus_fmc_select_p2,
                      membus_fmc_select_p1, membus_fmc_select_p0};
    assign wr_rs   = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};
    assign sel_bus = {membus_sel_p3, membus_sel_p2, membus_sel_p1, membus_sel_p0};
    // Word index is ma[22:35]; ma[21] does not take part in addressing a 16K module
    assign ma_idx[0] = membus_ma_p0[ADDR_W-1:0];
    assign ma_idx[1] = membus_ma_p1[ADDR_W-1:0];
    assign ma_idx[2] = membus_ma_p2[ADDR_W-1:0];
    assign ma_idx[3] = membus_ma_p3[ADDR_W-1:0];
    assign unused_ma_msb = ^{membus_ma_p3[MA_W-1], membus_ma_p2[MA_W-1],
                             membus_ma_p1[MA_W-1], membus_ma_p0[MA_W-1]};
    assign mb_in[0] = membus_mb_in_p0;
    assign mb_in[1] = membus_mb_in_p1;
    assign mb_in[2] = membus_mb_in_p2;
    assign mb_in[3] = membus_mb_in_p3;

    logic              grant_vld;
    logic [PORT_W-1:0] grant_idx;

    core_161c_arb #(
        .memsel_bus({memsel_p3, memsel_p2, memsel_p1, memsel_p0})
    ) u_arb (
        .power      (power),
        .rq_cyc     (rq_cyc),
        .rd_rq      (rd_rq),
        .wr_rq      (wr_rq),
        .fmc_select (fmc_sel),
        .sel        (sel_bus),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    state_t            state;
    logic [PORT_W-1:0] gnt_port;
    logic              is_rd, is_wr;
    logic [CNT_W-1:0]  cnt;
    logic [NPORT-1:0]  addr_ack_r, rd_rs_r;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata, rdata;
    logic              mem_we;
    logic [WORD_W-1:0] mem [DEPTH];

    // Cycle controller; power loss behaves like reset but leaves the array alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_port   <= '0;
            is_rd      <= 1'b0;
            is_wr      <= 1'b0;
            cnt        <= '0;
            addr_ack_r <= '0;
            rd_rs_r    <= '0;
        end else if (!power) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_ack_r <= '0;
            rd_rs_r    <= '0;
        end else begin
            addr_ack_r <= '0;
            rd_rs_r    <= '0;
            case (state)
                IDLE: if (grant_vld) begin
                    gnt_port              <= grant_idx;
                    is_rd                 <= rd_rq[grant_idx];
                    is_wr                 <= wr_rq[grant_idx];
                    addr_ack_r[grant_idx] <= 1'b1;
                    state                 <= ACK;
                end
                ACK: begin
                    cnt   <= '0;
                    state <= is_rd ? RD_WAIT : WR_WAIT;
                end
                RD_WAIT: if (cnt == last_cnt(RD_DLY)) begin
                    rd_rs_r[gnt_port] <= 1'b1;
                    state             <= RD_STROBE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RD_STROBE: state <= is_wr ? WR_WAIT : DONE;
                WR_WAIT: if (sw_restart) begin
                    state <= IDLE;
                end else if (wr_rs[gnt_port]) begin
                    cnt   <= '0;
                    state <= WR_CYCLE;
                end
                WR_CYCLE: if (cnt == last_cnt(WR_DLY)) state <= DONE;
                          else cnt <= cnt + 1'b1;
                // Hold until the requester lets go so one request is served once
                DONE: if (!rq_cyc[gnt_port]) state <= sw_single_step ? HALT : IDLE;
                HALT: if (sw_restart) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address and write-data holding registers; no reset needed on data
    always_ff @(posedge clk) begin
        if (power && state == IDLE && grant_vld) addr <= ma_idx[grant_idx];
        if (power && state == WR_WAIT && !sw_restart && wr_rs[gnt_port]) wdata <= mb_in[gnt_port];
    end

    assign mem_we = power && state == WR_CYCLE && cnt == last_cnt(WR_DLY);

    // Single-port array with registered read, shaped for block-RAM inference
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

    assign membus_addr_ack_p0 = power & addr_ack_r[0];
    assign membus_addr_ack_p1 = power & addr_ack_r[1];
    assign membus_addr_ack_p2 = power & addr_ack_r[2];
    assign membus_addr_ack_p3 = power & addr_ack_r[3];
    assign membus_rd_rs_p0    = power & rd_rs_r[0];
    assign membus_rd_rs_p1    = power & rd_rs_r[1];
    assign membus_rd_rs_p2    = power & rd_rs_r[2];
    assign membus_rd_rs_p3    = power & rd_rs_r[3];
    // The bus is wired-OR, so data is driven only during our own strobe
    assign membus_mb_out_p0   = membus_rd_rs_p0 ? rdata : '0;
    assign membus_mb_out_p1   = membus_rd_rs_p1 ? rdata : '0;
    assign membus_mb_out_p2   = membus_rd_rs_p2 ? rdata : '0;
    assign membus_mb_out_p3   = membus_rd_rs_p3 ? rdata : '0;
endmodule

// File: tb/tb_core_161c.sv
// Bench for core_161c: directed scenarios plus randomized traffic checked
// against an associative-array memory model.
module tb_core_161c;
    logic        clk = 1'b0;
    logic        reset, power, ss, rsw;
    logic [3:0]  rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
    logic [3:0]  sel   [4];
    logic [14:0] ma    [4];
    logic [35:0] mb_in [4];
    logic [3:0]  addr_ack, rd_rs;
    logic [35:0] mb_out [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [35:0] model [int];

    always #5 clk = ~clk;

    core_161c dut (
        .clk(clk), .reset(reset), .power(power), .sw_single_step(ss), .sw_restart(rsw),
        .membus_rq_cyc_p0(rq_cyc[0]), .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]),
        .membus_sel_p0(sel[0]), .membus_ma_p0(ma[0]), .membus_fmc_select_p0(fmc[0]),
        .membus_wr_rs_p0(wr_rs[0]), .membus_mb_in_p0(mb_in[0]),
        .membus_addr_ack_p0(addr_ack[0]), .membus_rd_rs_p0(rd_rs[0]), .membus_mb_out_p0(mb_out[0]),
        .membus_rq_cyc_p1(rq_cyc[1]), .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]),
        .membus_sel_p1(sel[1]), .membus_ma_p1(ma[1]), .membus_fmc_select_p1(fmc[1]),
        .membus_wr_rs_p1(wr_rs[1]), .membus_mb_in_p1(mb_in[1]),
        .membus_addr_ack_p1(addr_ack[1]), .membus_rd_rs_p1(rd_rs[1]), .membus_mb_out_p1(mb_out[1]),
        .membus_rq_cyc_p2(rq_cyc[2]), .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]),
        .membus_sel_p2(sel[2]), .membus_ma_p2(ma[2]), .membus_fmc_select_p2(fmc[2]),
        .membus_wr_rs_p2(wr_rs[2]), .membus_mb_in_p2(mb_in[2]),
        .membus_addr_ack_p2(addr_ack[2]), .membus_rd_rs_p2(rd_rs[2]), .membus_mb_out_p2(mb_out[2]),
        .membus_rq_cyc_p3(rq_cyc[3]), .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]),
        .membus_sel_p3(sel[3]), .membus_ma_p3(ma[3]), .membus_fmc_select_p3(fmc[3]),
        .membus_wr_rs_p3(wr_rs[3]), .membus_mb_in_p3(mb_in[3]),
        .membus_addr_ack_p3(addr_ack[3]), .membus_rd_rs_p3(rd_rs[3]), .membus_mb_out_p3(mb_out[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rq_cyc = '0; rd_rq = '0; wr_rq = '0; fmc = '0; wr_rs = '0; rsw = 1'b0; ss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel[i] = '0; ma[i] = '0; mb_in[i] = '0;
        end
    endtask

    function automatic logic [35:0] rand36();
        return {4'($urandom_range(15)), 32'($urandom())};
    endfunction

    // Runs one bus cycle on port p and reports what the bus showed.
    task automatic run_cycle(input int p, input logic [14:0] a, input bit do_rd, input bit do_wr,
                             input logic [35:0] wd, output logic [35:0] rd,
                             output int rd_lat, output bit ok);
        int ack_wait;
        ok = 1'b1; rd = '0; rd_lat = -1; ack_wait = -1;
        sel[p] = '0; ma[p] = a; rd_rq[p] = do_rd; wr_rq[p] = do_wr; rq_cyc[p] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (addr_ack[p]) begin ack_wait = i; break; end
        end
        if (ack_wait < 0) ok = 1'b0;
        if (ok && do_rd) begin
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (rd_rs[p]) begin rd_lat = i; rd = mb_out[p]; break; end
            end
            if (rd_lat < 0) ok = 1'b0;
        end
        if (ok && do_wr) begin
            tick();
            mb_in[p] = wd; wr_rs[p] = 1'b1;
            tick();
            wr_rs[p] = 1'b0; mb_in[p] = '0;
        end
        rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0; ma[p] = '0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        power = 1'b1; reset = 1'b1;
        rq_cyc[0] = 1'b1; rd_rq[0] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({addr_ack, rd_rs} !== 8'h00) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000000", {addr_ack, rd_rs});
        end
        n_cmp++;
        if ((mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3]) !== 36'h0) begin
            n_bad++; $display("FAIL reset_mb_out: got %o want 0", mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3]);
        end
        rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
        reset = 1'b0;
        // Unpowered module ignores requests
        power = 1'b0; rq_cyc[1] = 1'b1; rd_rq[1] = 1'b1;
        begin
            logic [3:0] seen = '0;
            repeat (8) begin tick(); seen |= addr_ack | rd_rs; end
            n_cmp++;
            if (seen !== 4'b0) begin
                n_bad++; $display("FAIL power_off_ack: got %b want 0000", seen);
            end
        end
        rq_cyc[1] = 1'b0; rd_rq[1] = 1'b0; power = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        logic [35:0] rd; int lat; bit ok;
        run_cycle(0, 15'o20, 1'b0, 1'b1, 36'o201040001234, rd, lat, ok);
        model[16] = 36'o201040001234;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_handshake: got ok=%0d want 1", ok); end
        run_cycle(0, 15'o20, 1'b1, 1'b0, '0, rd, lat, ok);
        n_cmp++;
        if (lat !== 5) begin n_bad++; $display("FAIL rd_latency: got %0d want 5", lat); end
        n_cmp++;
        if (rd !== 36'o201040001234) begin
            n_bad++; $display("FAIL rd_data: got %o want %o", rd, 36'o201040001234);
        end
    endtask

    task automatic test_no_double();
        int acks = 0; bit strobed = 1'b0;
        sel[1] = '0; ma[1] = 15'o20; rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (addr_ack[1]) acks++;
            if (rd_rs[1]) strobed = 1'b1;
        end
        n_cmp++;
        if (acks !== 1 || !strobed) begin
            n_bad++; $display("FAIL no_double: got acks=%0d strobe=%0d want acks=1 strobe=1", acks, strobed);
        end
        rq_cyc[1] = 1'b0; rd_rq[1] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_rmw();
        logic [35:0] rd; int lat; bit ok;
        run_cycle(0, 15'o1234, 1'b0, 1'b1, 36'o123456701234, rd, lat, ok);
        model[int'(15'o1234)] = 36'o123456701234;
        run_cycle(0, 15'o1234, 1'b1, 1'b1, 36'o777777777777, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 36'o123456701234) begin
            n_bad++; $display("FAIL rmw_old: got %o want %o", rd, 36'o123456701234);
        end
        model[int'(15'o1234)] = 36'o777777777777;
        run_cycle(0, 15'o1234, 1'b1, 1'b0, '0, rd, lat, ok);
        n_cmp++;
        if (rd !== 36'o777777777777) begin
            n_bad++; $display("FAIL rmw_new: got %o want %o", rd, 36'o777777777777);
        end
    endtask

    task automatic test_deselect();
        logic [3:0] strobes; logic [35:0] data;
        for (int k = 0; k < 2; k++) begin
            strobes = '0; data = '0;
            sel[0] = (k == 0) ? 4'b0001 : 4'b0000; fmc[0] = (k == 1);
            ma[0] = 15'o20; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
            repeat (15) begin
                tick();
                strobes |= addr_ack | rd_rs;
                data |= mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3];
            end
            n_cmp++;
            if (strobes !== 4'b0) begin
                n_bad++; $display("FAIL deselect_%0d_strobes: got %b want 0000", k, strobes);
            end
            n_cmp++;
            if (data !== 36'h0) begin
                n_bad++; $display("FAIL deselect_%0d_mb_out: got %o want 0", k, data);
            end
            rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0; fmc[0] = 1'b0; sel[0] = '0;
            repeat (2) tick();
        end
    endtask

    task automatic test_priority();
        logic [35:0] rd, v0, v2; int lat; bit ok; bit early = 1'b0; int w2 = -1;
        logic [35:0] d0 = '0; logic [35:0] d2 = '0; logic [35:0] other = '0;
        v0 = rand36(); v2 = rand36();
        run_cycle(0, 15'o100, 1'b0, 1'b1, v0, rd, lat, ok); model[64] = v0;
        run_cycle(2, 15'o200, 1'b0, 1'b1, v2, rd, lat, ok); model[128] = v2;
        ma[0] = 15'o100; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
        ma[2] = 15'o200; rd_rq[2] = 1'b1; rq_cyc[2] = 1'b1;
        tick();
        n_cmp++;
        if (addr_ack !== 4'b0001) begin
            n_bad++; $display("FAIL prio_first_ack: got %b want 0001", addr_ack);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (addr_ack[2]) early = 1'b1;
            if (rd_rs[0]) d0 = mb_out[0];
        end
        rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
        n_cmp++;
        if (d0 !== model[64]) begin n_bad++; $display("FAIL prio_p0_data: got %o want %o", d0, model[64]); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (addr_ack[2]) begin w2 = i; break; end
        end
        n_cmp++;
        if (early || w2 < 0) begin
            n_bad++; $display("FAIL prio_p2_ack: got early=%0d wait=%0d want early=0 wait>0", early, w2);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rd_rs[2]) begin d2 = mb_out[2]; other = mb_out[0] | mb_out[1] | mb_out[3]; break; end
        end
        n_cmp++;
        if (d2 !== model[128] || other !== 36'h0) begin
            n_bad++; $display("FAIL prio_p2_data: got %o other=%o want %o other=0", d2, other, model[128]);
        end
        rq_cyc[2] = 1'b0; rd_rq[2] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_power_abort();
        logic [35:0] rd, v1; int lat; bit ok; bit acked = 1'b0;
        v1 = rand36();
        run_cycle(3, 15'o3333, 1'b0, 1'b1, v1, rd, lat, ok); model[int'(15'o3333)] = v1;
        ma[3] = 15'o3333; wr_rq[3] = 1'b1; rq_cyc[3] = 1'b1;
        for (int i = 0; i < 20 && !acked; i++) begin tick(); acked = addr_ack[3]; end
        tick();
        mb_in[3] = ~v1; wr_rs[3] = 1'b1;
        tick();
        wr_rs[3] = 1'b0;
        repeat (3) tick();
        power = 1'b0;
        #1;
        n_cmp++;
        if ({addr_ack, rd_rs} !== 8'h00 || mb_out[3] !== 36'h0) begin
            n_bad++; $display("FAIL pwr_outputs: got %b %o want 0", {addr_ack, rd_rs}, mb_out[3]);
        end
        tick();
        rq_cyc[3] = 1'b0; wr_rq[3] = 1'b0; mb_in[3] = '0;
        repeat (2) tick();
        power = 1'b1;
        tick();
        run_cycle(3, 15'o3333, 1'b1, 1'b0, '0, rd, lat, ok);
        n_cmp++;
        if (!acked || rd !== v1) begin
            n_bad++; $display("FAIL pwr_word: got %o acked=%0d want %o acked=1", rd, acked, v1);
        end
    endtask

    task automatic test_restart_abort();
        logic [35:0] rd; int lat; bit ok; bit acked = 1'b0;
        ma[0] = 15'o3333; wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
        for (int i = 0; i < 20 && !acked; i++) begin tick(); acked = addr_ack[0]; end
        tick();
        rsw = 1'b1; rq_cyc[0] = 1'b0; wr_rq[0] = 1'b0;
        tick();
        rsw = 1'b0;
        mb_in[0] = 36'o555555555555; wr_rs[0] = 1'b1;
        tick();
        wr_rs[0] = 1'b0; mb_in[0] = '0;
        repeat (6) tick();
        run_cycle(0, 15'o3333, 1'b1, 1'b0, '0, rd, lat, ok);
        n_cmp++;
        if (!acked || rd !== model[int'(15'o3333)]) begin
            n_bad++; $display("FAIL restart_abort: got %o want %o", rd, model[int'(15'o3333)]);
        end
    endtask

    task automatic test_single_step();
        logic [35:0] rd; int lat; bit ok; int held = 0; int w = -1; logic [35:0] d = '0;
        ss = 1'b1;
        run_cycle(1, 15'o20, 1'b1, 1'b0, '0, rd, lat, ok);
        ma[1] = 15'o20; rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1;
        repeat (12) begin tick(); if (addr_ack[1]) held++; end
        n_cmp++;
        if (held !== 0) begin n_bad++; $display("FAIL sstep_halt: got %0d acks want 0", held); end
        rsw = 1'b1; tick(); rsw = 1'b0; ss = 1'b0;
        if (addr_ack[1]) w = 0;
        for (int i = 1; i <= 10 && w < 0; i++) begin tick(); if (addr_ack[1]) w = i; end
        for (int i = 1; i <= 10; i++) begin tick(); if (rd_rs[1]) begin d = mb_out[1]; break; end end
        n_cmp++;
        if (w < 0 || d !== model[16]) begin
            n_bad++; $display("FAIL sstep_restart: got wait=%0d data=%o want ack, %o", w, d, model[16]);
        end
        rq_cyc[1] = 1'b0; rd_rq[1] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        logic [14:0] pool [6];
        logic [35:0] rd, wd; int lat; bit ok; int p; int k; int op;
        for (int i = 0; i < 6; i++) begin
            pool[i] = 15'($urandom_range(16383)) | 15'h4000;
            wd = rand36();
            run_cycle(int'($urandom_range(3)), pool[i], 1'b0, 1'b1, wd, rd, lat, ok);
            model[int'(pool[i][13:0])] = wd;
        end
        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(3)); k = int'($urandom_range(5)); op = int'($urandom_range(2));
            wd = rand36();
            run_cycle(p, pool[k], op != 1, op != 0, wd, rd, lat, ok);
            n_cmp++;
            if (!ok || (op != 1 && (lat !== 5 || rd !== model[int'(pool[k][13:0])]))) begin
                n_bad++;
                $display("FAIL rand_%0d p%0d op%0d: got %o lat=%0d ok=%0d want %o lat=5",
                         t, p, op, rd, lat, ok, model[int'(pool[k][13:0])]);
            end
            if (op != 0) model[int'(pool[k][13:0])] = wd;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_no_double();
        test_rmw();
        test_deselect();
        test_priority();
        test_power_abort();
        test_restart_abort();
        test_single_step();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
